// File: rtl/ps2_dir_decoder.sv
// PS/2 keyboard receiver with prefix decoding, scancode FIFO and snake
// direction tracking, all in the VGA_clk domain.
//
// Ports:
//   VGA_clk, rst_n       system clock, async active-low reset
//   KB_clk, KB_data      raw asynchronous PS/2 lines
//   code_valid/ready     show-ahead FIFO handshake
//   code_byte/ext/brk    head entry: scancode, E0 prefix, F0 prefix
//   direction            one-hot up/left/down/right, 0000 until first key
//   parity_err           pulse: bad odd parity
//   frame_err            pulse: bad stop bit or inter-bit timeout
//   overflow             pulse: entry dropped because FIFO full
module ps2_dir_decoder #(
   parameter int unsigned FILTER_LEN     = 4,
   parameter int unsigned TIMEOUT_CYCLES = 25000,
   parameter int unsigned FIFO_DEPTH     = 4,
   parameter logic [7:0]  KEY_UP         = 8'h1D,
   parameter logic [7:0]  KEY_LEFT       = 8'h1C,
   parameter logic [7:0]  KEY_DOWN       = 8'h1B,
   parameter logic [7:0]  KEY_RIGHT      = 8'h23,
   parameter logic [7:0]  EXT_UP         = 8'h75,
   parameter logic [7:0]  EXT_LEFT       = 8'h6B,
   parameter logic [7:0]  EXT_DOWN       = 8'h72,
   parameter logic [7:0]  EXT_RIGHT      = 8'h74,
   parameter bit          ALLOW_REVERSE  = 1'b0
) (
   input  logic       VGA_clk,
   input  logic       rst_n,
   input  logic       KB_clk,
   input  logic       KB_data,
   output logic       code_valid,
   input  logic       code_ready,
   output logic [7:0] code_byte,
   output logic       code_ext,
   output logic       code_brk,
   output logic [3:0] direction,
   output logic       parity_err,
   output logic       frame_err,
   output logic       overflow
);

   localparam int unsigned FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
   localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam int unsigned AW = $clog2(FIFO_DEPTH);

   typedef enum logic [1:0] {
      S_IDLE,
      S_DATA,
      S_PARITY,
      S_STOP
   } state_t;

   // ---------------- input synchronisers and glitch filter
   logic          kc_s1_q, kc_s2_q;
   logic          kd_s1_q, kd_s2_q;
   logic          fclk_q, fclk_prev_q;
   logic [FW-1:0] fcnt_q;
   logic          sample;

   always_ff @(posedge VGA_clk or negedge rst_n) begin
      if (!rst_n) begin
         kc_s1_q     <= 1'b1;
         kc_s2_q     <= 1'b1;
         kd_s1_q     <= 1'b1;
         kd_s2_q     <= 1'b1;
         fclk_q      <= 1'b1;
         fclk_prev_q <= 1'b1;
         fcnt_q      <= '0;
      end else begin
         kc_s1_q     <= KB_clk;
         kc_s2_q     <= kc_s1_q;
         kd_s1_q     <= KB_data;
         kd_s2_q     <= kd_s1_q;
         fclk_prev_q <= fclk_q;
         if (kc_s2_q != fclk_q) begin
            if (fcnt_q == FW'(FILTER_LEN - 1)) begin
               fclk_q <= kc_s2_q;
               fcnt_q <= '0;
            end else begin
               fcnt_q <= fcnt_q + 1'b1;
            end
         end else begin
            fcnt_q <= '0;
         end
      end
   end

   assign sample = fclk_prev_q & ~fclk_q;

   // ---------------- frame receiver
   state_t        state_q;
   logic [2:0]    bitcnt_q;
   logic [7:0]    shift_q;
   logic          par_q;
   logic [TW-1:0] tcnt_q;
   logic          byte_ok_q;
   logic [7:0]    rx_byte_q;
   logic          perr_q, ferr_q;

   always_ff @(posedge VGA_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         bitcnt_q  <= '0;
         shift_q   <= '0;
         par_q     <= 1'b0;
         tcnt_q    <= '0;
         byte_ok_q <= 1'b0;
         rx_byte_q <= '0;
         perr_q    <= 1'b0;
         ferr_q    <= 1'b0;
      end else begin
         byte_ok_q <= 1'b0;
         perr_q    <= 1'b0;
         ferr_q    <= 1'b0;
         if (sample) begin
            tcnt_q <= '0;
            unique case (state_q)
               S_IDLE: begin
                  if (!kd_s2_q) begin
                     state_q  <= S_DATA;
                     bitcnt_q <= '0;
                  end
               end
               S_DATA: begin
                  shift_q  <= {kd_s2_q, shift_q[7:1]};
                  bitcnt_q <= bitcnt_q + 1'b1;
                  if (bitcnt_q == 3'd7) state_q <= S_PARITY;
               end
               S_PARITY: begin
                  par_q   <= kd_s2_q;
                  state_q <= S_STOP;
               end
               S_STOP: begin
                  state_q <= S_IDLE;
                  // A bad stop bit takes precedence over parity.
                  if (!kd_s2_q) begin
                     ferr_q <= 1'b1;
                  end else if (^{par_q, shift_q}) begin
                     byte_ok_q <= 1'b1;
                     rx_byte_q <= shift_q;
                  end else begin
                     perr_q <= 1'b1;
                  end
               end
               default: state_q <= S_IDLE;
            endcase
         end else if (state_q == S_IDLE) begin
            tcnt_q <= '0;
         end else if (tcnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
            ferr_q  <= 1'b1;
            state_q <= S_IDLE;
            tcnt_q  <= '0;
         end else begin
            tcnt_q <= tcnt_q + 1'b1;
         end
      end
   end

   // ---------------- prefix resolution
   logic ext_q, brk_q;
   logic is_e0, is_f0, ent_vld;

   assign is_e0   = (rx_byte_q == 8'hE0);
   assign is_f0   = (rx_byte_q == 8'hF0);
   assign ent_vld = byte_ok_q & ~is_e0 & ~is_f0;

   always_ff @(posedge VGA_clk or negedge rst_n) begin
      if (!rst_n) begin
         ext_q <= 1'b0;
         brk_q <= 1'b0;
      end else if (perr_q || ferr_q) begin
         ext_q <= 1'b0;
         brk_q <= 1'b0;
      end else if (byte_ok_q) begin
         if (is_e0) begin
            ext_q <= 1'b1;
         end else if (is_f0) begin
            brk_q <= 1'b1;
         end else begin
            ext_q <= 1'b0;
            brk_q <= 1'b0;
         end
      end
   end

   // ---------------- scancode FIFO (extra pointer bit tells full from empty)
   logic [9:0]  mem_q [FIFO_DEPTH];
   logic [AW:0] wptr_q, rptr_q;
   logic        ovf_q;
   logic        empty, full, pop, push;

   assign empty = (wptr_q == rptr_q);
   assign full  = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) &&
                  (wptr_q[AW] != rptr_q[AW]);
   assign pop   = ~empty & code_ready;
   assign push  = ent_vld & (~full | pop);

   always_ff @(posedge VGA_clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(FIFO_DEPTH); i++) mem_q[i] <= '0;
         wptr_q <= '0;
         rptr_q <= '0;
         ovf_q  <= 1'b0;
      end else begin
         ovf_q <= ent_vld & full & ~pop;
         if (push) begin
            mem_q[wptr_q[AW-1:0]] <= {ext_q, brk_q, rx_byte_q};
            wptr_q <= wptr_q + 1'b1;
         end
         if (pop) rptr_q <= rptr_q + 1'b1;
      end
   end

   // ---------------- direction tracking
   logic [3:0] dir_q, req_dir, opp_dir;

   always_comb begin
      req_dir = 4'b0000;
      if (ent_vld && !brk_q) begin
         if (!ext_q) begin
            if (rx_byte_q == KEY_UP)         req_dir = 4'b0001;
            else if (rx_byte_q == KEY_LEFT)  req_dir = 4'b0010;
            else if (rx_byte_q == KEY_DOWN)  req_dir = 4'b0100;
            else if (rx_byte_q == KEY_RIGHT) req_dir = 4'b1000;
         end else begin
            if (rx_byte_q == EXT_UP)         req_dir = 4'b0001;
            else if (rx_byte_q == EXT_LEFT)  req_dir = 4'b0010;
            else if (rx_byte_q == EXT_DOWN)  req_dir = 4'b0100;
            else if (rx_byte_q == EXT_RIGHT) req_dir = 4'b1000;
         end
      end
   end

   // Rotating the one-hot by two gives the opposite heading.
   assign opp_dir = {dir_q[1:0], dir_q[3:2]};

   always_ff @(posedge VGA_clk or negedge rst_n) begin
      if (!rst_n) begin
         dir_q <= 4'b0000;
      end else if (req_dir != 4'b0000) begin
         if (ALLOW_REVERSE || (req_dir != opp_dir)) dir_q <= req_dir;
      end
   end

   assign code_valid = ~empty;
   assign code_byte  = mem_q[rptr_q[AW-1:0]][7:0];
   assign code_brk   = mem_q[rptr_q[AW-1:0]][8];
   assign code_ext   = mem_q[rptr_q[AW-1:0]][9];
   assign direction  = dir_q;
   assign parity_err = perr_q;
   assign frame_err  = ferr_q;
   assign overflow   = ovf_q;

endmodule

// File: tb/tb_ps2_dir_decoder.sv
// Directed testbench for ps2_dir_decoder: frames, prefixes, errors,
// FIFO overflow, reverse lockout, glitch rejection and async reset.
module tb_ps2_dir_decoder;

   localparam int TMO = 300;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       kb_clk = 1'b1;
   logic       kb_data = 1'b1;
   logic       code_valid;
   logic       code_ready = 1'b0;
   logic [7:0] code_byte;
   logic       code_ext, code_brk;
   logic [3:0] direction;
   logic       parity_err, frame_err, overflow;

   int checks = 0;
   int errors = 0;
   int n_perr = 0;
   int n_ferr = 0;
   int n_ovf  = 0;

   ps2_dir_decoder #(
      .FILTER_LEN(4),
      .TIMEOUT_CYCLES(TMO),
      .FIFO_DEPTH(4)
   ) dut (
      .VGA_clk(clk),
      .rst_n(rst_n),
      .KB_clk(kb_clk),
      .KB_data(kb_data),
      .code_valid(code_valid),
      .code_ready(code_ready),
      .code_byte(code_byte),
      .code_ext(code_ext),
      .code_brk(code_brk),
      .direction(direction),
      .parity_err(parity_err),
      .frame_err(frame_err),
      .overflow(overflow)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (parity_err) n_perr++;
      if (frame_err)  n_ferr++;
      if (overflow)   n_ovf++;
   end

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_bit(input logic b);
      kb_data = b;
      wait_cyc(6);
      kb_clk = 1'b0;
      wait_cyc(10);
      kb_clk = 1'b1;
      wait_cyc(10);
   endtask

   task automatic send_frame(input logic [7:0] b, input logic bad_par,
                             input logic stop);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(b[i]);
      send_bit(~(^b) ^ bad_par);
      send_bit(stop);
      kb_data = 1'b1;
      wait_cyc(12);
   endtask

   task automatic pop_one();
      @(negedge clk);
      code_ready = 1'b1;
      @(negedge clk);
      code_ready = 1'b0;
   endtask

   task automatic test_reset();
      wait_cyc(3);
      checks++; if (code_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", code_valid); end
      checks++; if (code_byte !== 8'h00) begin errors++; $display("FAIL rst_byte got %h want 00", code_byte); end
      checks++; if ({code_ext, code_brk} !== 2'b00) begin errors++; $display("FAIL rst_flags got %b want 00", {code_ext, code_brk}); end
      checks++; if (direction !== 4'b0000) begin errors++; $display("FAIL rst_dir got %b want 0000", direction); end
      checks++; if ({parity_err, frame_err, overflow} !== 3'b000) begin errors++; $display("FAIL rst_pulses got %b want 000", {parity_err, frame_err, overflow}); end
      rst_n = 1'b1;
      wait_cyc(5);
   endtask

   task automatic test_basic();
      send_frame(8'h1D, 1'b0, 1'b1);
      checks++; if (code_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got %b want 1", code_valid); end
      checks++; if (code_byte !== 8'h1D) begin errors++; $display("FAIL basic_byte got %h want 1d", code_byte); end
      checks++; if ({code_ext, code_brk} !== 2'b00) begin errors++; $display("FAIL basic_flags got %b want 00", {code_ext, code_brk}); end
      checks++; if (direction !== 4'b0001) begin errors++; $display("FAIL basic_dir got %b want 0001", direction); end
      checks++; if (n_perr + n_ferr + n_ovf !== 0) begin errors++; $display("FAIL basic_pulses got %0d want 0", n_perr + n_ferr + n_ovf); end
      pop_one();
      checks++; if (code_valid !== 1'b0) begin errors++; $display("FAIL basic_pop got %b want 0", code_valid); end
   endtask

   task automatic test_prefix();
      send_frame(8'hE0, 1'b0, 1'b1);
      send_frame(8'hF0, 1'b0, 1'b1);
      checks++; if (code_valid !== 1'b0) begin errors++; $display("FAIL pfx_noenq got %b want 0", code_valid); end
      send_frame(8'h75, 1'b0, 1'b1);
      checks++; if ({code_valid, code_ext, code_brk, code_byte} !== {3'b111, 8'h75}) begin errors++; $display("FAIL pfx_brk got %b_%h want 111_75", {code_valid, code_ext, code_brk}, code_byte); end
      checks++; if (direction !== 4'b0001) begin errors++; $display("FAIL pfx_brk_dir got %b want 0001", direction); end
      pop_one();
      checks++; if (code_valid !== 1'b0) begin errors++; $display("FAIL pfx_single got %b want 0", code_valid); end
      send_frame(8'hE0, 1'b0, 1'b1);
      send_frame(8'h6B, 1'b0, 1'b1);
      checks++; if ({code_valid, code_ext, code_brk, code_byte} !== {3'b110, 8'h6B}) begin errors++; $display("FAIL pfx_ext got %b_%h want 110_6b", {code_valid, code_ext, code_brk}, code_byte); end
      checks++; if (direction !== 4'b0010) begin errors++; $display("FAIL pfx_ext_dir got %b want 0010", direction); end
      pop_one();
      send_frame(8'h1B, 1'b0, 1'b1);
      checks++; if (direction !== 4'b0100) begin errors++; $display("FAIL pfx_down_dir got %b want 0100", direction); end
      pop_one();
   endtask

   task automatic test_parity();
      int p0;
      p0 = n_perr;
      send_frame(8'h23, 1'b1, 1'b1);
      checks++; if (n_perr - p0 !== 1) begin errors++; $display("FAIL par_pulse got %0d want 1", n_perr - p0); end
      checks++; if (code_valid !== 1'b0) begin errors++; $display("FAIL par_noenq got %b want 0", code_valid); end
      checks++; if (direction !== 4'b0100) begin errors++; $display("FAIL par_dir got %b want 0100", direction); end
      send_frame(8'h23, 1'b0, 1'b1);
      checks++; if (direction !== 4'b1000) begin errors++; $display("FAIL par_good_dir got %b want 1000", direction); end
      checks++; if (code_byte !== 8'h23) begin errors++; $display("FAIL par_good_byte got %h want 23", code_byte); end
      pop_one();
   endtask

   task automatic test_stopbit();
      int f0, p0;
      f0 = n_ferr;
      p0 = n_perr;
      send_frame(8'h1D, 1'b1, 1'b0);
      checks++; if (n_ferr - f0 !== 1) begin errors++; $display("FAIL stop_ferr got %0d want 1", n_ferr - f0); end
      checks++; if (n_perr - p0 !== 0) begin errors++; $display("FAIL stop_perr got %0d want 0", n_perr - p0); end
      checks++; if (code_valid !== 1'b0) begin errors++; $display("FAIL stop_noenq got %b want 0", code_valid); end
   endtask

   task automatic test_timeout();
      int f0;
      f0 = n_ferr;
      send_bit(1'b0);
      for (int i = 0; i < 4; i++) send_bit(1'b1);
      wait_cyc(TMO + 40);
      checks++; if (n_ferr - f0 !== 1) begin errors++; $display("FAIL tmo_pulse got %0d want 1", n_ferr - f0); end
      checks++; if (code_valid !== 1'b0) begin errors++; $display("FAIL tmo_noenq got %b want 0", code_valid); end
      send_frame(8'h1C, 1'b0, 1'b1);
      checks++; if ({code_valid, code_byte} !== {1'b1, 8'h1C}) begin errors++; $display("FAIL tmo_next got %b_%h want 1_1c", code_valid, code_byte); end
      checks++; if (direction !== 4'b1000) begin errors++; $display("FAIL tmo_lockout_dir got %b want 1000", direction); end
      checks++; if (n_ferr - f0 !== 1) begin errors++; $display("FAIL tmo_extra got %0d want 1", n_ferr - f0); end
      pop_one();
   endtask

   task automatic test_overflow();
      logic [7:0] exp_b [4];
      int o0;
      exp_b[0] = 8'h1D; exp_b[1] = 8'h1C; exp_b[2] = 8'h1B; exp_b[3] = 8'h23;
      o0 = n_ovf;
      for (int i = 0; i < 4; i++) send_frame(exp_b[i], 1'b0, 1'b1);
      checks++; if (n_ovf - o0 !== 0) begin errors++; $display("FAIL ovf_early got %0d want 0", n_ovf - o0); end
      send_frame(8'h2B, 1'b0, 1'b1);
      checks++; if (n_ovf - o0 !== 1) begin errors++; $display("FAIL ovf_pulse got %0d want 1", n_ovf - o0); end
      checks++; if (direction !== 4'b1000) begin errors++; $display("FAIL ovf_dir got %b want 1000", direction); end
      for (int i = 0; i < 4; i++) begin
         checks++; if ({code_valid, code_byte} !== {1'b1, exp_b[i]}) begin errors++; $display("FAIL ovf_drain%0d got %b_%h want 1_%h", i, code_valid, code_byte, exp_b[i]); end
         pop_one();
      end
      checks++; if (code_valid !== 1'b0) begin errors++; $display("FAIL ovf_empty got %b want 0", code_valid); end
   endtask

   task automatic test_reverse();
      int f0;
      send_frame(8'h1D, 1'b0, 1'b1);
      checks++; if (direction !== 4'b0001) begin errors++; $display("FAIL rev_up got %b want 0001", direction); end
      pop_one();
      send_frame(8'h1B, 1'b0, 1'b1);
      checks++; if (direction !== 4'b0001) begin errors++; $display("FAIL rev_block got %b want 0001", direction); end
      checks++; if (code_byte !== 8'h1B) begin errors++; $display("FAIL rev_block_byte got %h want 1b", code_byte); end
      pop_one();
      send_frame(8'h1C, 1'b0, 1'b1);
      checks++; if (direction !== 4'b0010) begin errors++; $display("FAIL rev_left got %b want 0010", direction); end
      pop_one();
      f0 = n_ferr;
      kb_data = 1'b0;
      wait_cyc(2);
      kb_clk = 1'b0;
      wait_cyc(2);
      kb_clk = 1'b1;
      kb_data = 1'b1;
      wait_cyc(10);
      send_frame(8'h1D, 1'b0, 1'b1);
      checks++; if ({code_valid, code_byte} !== {1'b1, 8'h1D}) begin errors++; $display("FAIL glitch_byte got %b_%h want 1_1d", code_valid, code_byte); end
      checks++; if (direction !== 4'b0001) begin errors++; $display("FAIL glitch_dir got %b want 0001", direction); end
      checks++; if (n_ferr - f0 !== 0) begin errors++; $display("FAIL glitch_ferr got %0d want 0", n_ferr - f0); end
   endtask

   task automatic test_mid_reset();
      send_bit(1'b0);
      for (int i = 0; i < 3; i++) send_bit(1'b0);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      checks++; if (code_valid !== 1'b0) begin errors++; $display("FAIL mrst_valid got %b want 0", code_valid); end
      checks++; if (direction !== 4'b0000) begin errors++; $display("FAIL mrst_dir got %b want 0000", direction); end
      checks++; if (code_byte !== 8'h00) begin errors++; $display("FAIL mrst_byte got %h want 00", code_byte); end
      wait_cyc(3);
      kb_data = 1'b1;
      rst_n = 1'b1;
      wait_cyc(5);
      send_frame(8'h1B, 1'b0, 1'b1);
      checks++; if ({code_valid, code_byte} !== {1'b1, 8'h1B}) begin errors++; $display("FAIL mrst_after got %b_%h want 1_1b", code_valid, code_byte); end
      checks++; if (direction !== 4'b0100) begin errors++; $display("FAIL mrst_after_dir got %b want 0100", direction); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_prefix();
      test_parity();
      test_stopbit();
      test_timeout();
      test_overflow();
      test_reverse();
      test_mid_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
